// File: rtl/merge_rr_arbiter.sv
// Two-input round-robin arbiter feeding the merge stage: one output register,
// strict alternation under contention, and saturating per-port grant counters.
module merge_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] grant1_cnt,
    output logic [CNT_W-1:0] grant2_cnt
);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_P1   = 2'd1,
        GRANT_P2   = 2'd2
    } grant_t;

    grant_t last_grant;
    grant_t grant;
    logic   load_en;

    assign load_en = !out_valid || out_ready;

    // Grant is held off during reset so no ready can pulse while rst_n is low.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n && load_en) begin
            if (in1_valid && in2_valid) begin
                grant = (last_grant == GRANT_P1) ? GRANT_P2 : GRANT_P1;
            end else if (in1_valid) begin
                grant = GRANT_P1;
            end else if (in2_valid) begin
                grant = GRANT_P2;
            end
        end
    end

    assign in1_ready = (grant == GRANT_P1);
    assign in2_ready = (grant == GRANT_P2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sel    <= 2'd0;
            out_data   <= '0;
            last_grant <= GRANT_P2;
            grant1_cnt <= '0;
            grant2_cnt <= '0;
        end else if (load_en) begin
            if (grant != GRANT_NONE) begin
                out_valid  <= 1'b1;
                out_sel    <= grant;
                out_data   <= (grant == GRANT_P1) ? in1_data : in2_data;
                last_grant <= grant;
                // Counters stick at all-ones rather than wrapping.
                if (grant == GRANT_P1 && grant1_cnt != {CNT_W{1'b1}}) begin
                    grant1_cnt <= grant1_cnt + 1'b1;
                end
                if (grant == GRANT_P2 && grant2_cnt != {CNT_W{1'b1}}) begin
                    grant2_cnt <= grant2_cnt + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
                out_sel   <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_merge_rr_arbiter.sv
// Directed self-checking bench for merge_rr_arbiter (CNT_W=4 so saturation is reachable).
module tb_merge_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in1_valid, in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in2_valid, in2_ready;
    logic [WIDTH-1:0] in2_data;
    logic             out_valid, out_ready;
    logic [1:0]       out_sel;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] grant1_cnt, grant2_cnt;

    int checks = 0;
    int errors = 0;

    merge_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data),
        .grant1_cnt(grant1_cnt), .grant2_cnt(grant2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in1_valid = 1'b0; in2_valid = 1'b0;
        in1_data = '0; in2_data = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in1_valid = 1'b1; in2_valid = 1'b1;
        in1_data = 8'hEE; in2_data = 8'hDD;
        out_ready = 1'b1;
        #1;
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in1_ready: got %b expected 0", in1_ready); end
        checks++; if (in2_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in2_ready: got %b expected 0", in2_ready); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_sel: got %0d expected 0", out_sel); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (grant1_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt1: got %0d expected 0", grant1_cnt); end
        checks++; if (grant2_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt2: got %0d expected 0", grant2_cnt); end
        checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_held: got %b%b expected 00", in1_ready, in2_ready); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_sel;
        logic [7:0] exp_data;
        apply_reset();
        in1_valid = 1'b1; in1_data = 8'h11;
        in2_valid = 1'b1; in2_data = 8'h22;
        #1;
        checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin errors++; $display("[TB] FAIL contention_first_ready: got %b%b expected 10", in1_ready, in2_ready); end
        for (int i = 0; i < 4; i++) begin
            exp_sel  = (i % 2 == 0) ? 2'd1 : 2'd2;
            exp_data = (i % 2 == 0) ? 8'h11 : 8'h22;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL contention_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_sel !== exp_sel) begin errors++; $display("[TB] FAIL contention_sel[%0d]: got %0d expected %0d", i, out_sel, exp_sel); end
            checks++; if (out_data !== exp_data) begin errors++; $display("[TB] FAIL contention_data[%0d]: got %h expected %h", i, out_data, exp_data); end
        end
        checks++; if (grant1_cnt !== 4'd2) begin errors++; $display("[TB] FAIL contention_cnt1: got %0d expected 2", grant1_cnt); end
        checks++; if (grant2_cnt !== 4'd2) begin errors++; $display("[TB] FAIL contention_cnt2: got %0d expected 2", grant2_cnt); end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_single_port();
        logic [7:0] exp_data;
        apply_reset();
        in2_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_data = 8'hA0 + 8'(i);
            in2_data = exp_data;
            #1;
            checks++; if (in2_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready[%0d]: got %b%b expected 01", i, in1_ready, in2_ready); end
            @(posedge clk); #1;
            checks++; if (out_sel !== 2'd2) begin errors++; $display("[TB] FAIL single_sel[%0d]: got %0d expected 2", i, out_sel); end
            checks++; if (out_data !== exp_data) begin errors++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, out_data, exp_data); end
        end
        in1_valid = 1'b1; in1_data = 8'h11; in2_data = 8'h22;
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd1) begin errors++; $display("[TB] FAIL single_then_both_sel: got %0d expected 1", out_sel); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("[TB] FAIL single_then_both_data: got %h expected 11", out_data); end
        checks++; if (grant2_cnt !== 4'd3) begin errors++; $display("[TB] FAIL single_cnt2: got %0d expected 3", grant2_cnt); end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        in1_valid = 1'b1; in1_data = 8'h11;
        in2_valid = 1'b1; in2_data = 8'h22;
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd1 || out_data !== 8'h11) begin errors++; $display("[TB] FAIL bp_first_load: got sel=%0d data=%h expected sel=1 data=11", out_sel, out_data); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b%b expected 00", i, in1_ready, in2_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=1 data=11", i, out_valid, out_sel, out_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b%b expected 01", in1_ready, in2_ready); end
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd2 || out_data !== 8'h22) begin errors++; $display("[TB] FAIL bp_release_load: got sel=%0d data=%h expected sel=2 data=22", out_sel, out_data); end
        checks++; if (grant1_cnt !== 4'd1 || grant2_cnt !== 4'd1) begin errors++; $display("[TB] FAIL bp_cnts: got %0d/%0d expected 1/1", grant1_cnt, grant2_cnt); end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_idle();
        apply_reset();
        in1_valid = 1'b1; in1_data = 8'h77;
        @(posedge clk); #1;
        in1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0) begin errors++; $display("[TB] FAIL idle[%0d]: got v=%b sel=%0d expected v=0 sel=0", i, out_valid, out_sel); end
        end
        in1_valid = 1'b1; in1_data = 8'h5C;
        #1;
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_accept_ready: got %b expected 1", in1_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h5C) begin errors++; $display("[TB] FAIL idle_token: got v=%b sel=%0d data=%h expected v=1 sel=1 data=5c", out_valid, out_sel, out_data); end
        in2_valid = 1'b1; in2_data = 8'h99;
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd2 || out_data !== 8'h99) begin errors++; $display("[TB] FAIL idle_fairness: got sel=%0d data=%h expected sel=2 data=99", out_sel, out_data); end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        in1_valid = 1'b1; in1_data = 8'h33;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin errors++; $display("[TB] FAIL areset_preload: got v=%b data=%h expected v=1 data=33", out_valid, out_data); end
        out_ready = 1'b0;
        in1_valid = 1'b1; in2_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0) begin errors++; $display("[TB] FAIL areset_out: got v=%b sel=%0d expected v=0 sel=0", out_valid, out_sel); end
        checks++; if (grant1_cnt !== 4'd0 || grant2_cnt !== 4'd0) begin errors++; $display("[TB] FAIL areset_cnts: got %0d/%0d expected 0/0", grant1_cnt, grant2_cnt); end
        out_ready = 1'b1;
        #1;
        checks++; if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_ready: got %b%b expected 00", in1_ready, in2_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        in1_data = 8'h11; in2_data = 8'h22;
        @(posedge clk); #1;
        checks++; if (out_sel !== 2'd1 || out_data !== 8'h11) begin errors++; $display("[TB] FAIL areset_first_grant: got sel=%0d data=%h expected sel=1 data=11", out_sel, out_data); end
        in1_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        logic [7:0]       exp_data;
        apply_reset();
        in1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_data = 8'h40 + 8'(i);
            exp_cnt  = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            in1_data = exp_data;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== exp_data) begin errors++; $display("[TB] FAIL sat_token[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=1 data=%h", i, out_valid, out_sel, out_data, exp_data); end
            checks++; if (grant1_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL sat_cnt1[%0d]: got %0d expected %0d", i, grant1_cnt, exp_cnt); end
        end
        checks++; if (grant2_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sat_cnt2: got %0d expected 0", grant2_cnt); end
        in1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_port();
        test_backpressure();
        test_idle();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
